// File: rtl/tcam_rslt_rdr.sv
// TCAM result reader: buffers {status, rule ID} words from the lookup pipeline
// in a small first-word-fall-through queue and tracks overflow and single-match hits.
module tcam_rslt_rdr #(
  parameter int WID    = 10,
  parameter int RIDW   = 8,
  parameter int DEP    = 4,
  parameter int DROPNM = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ivld,
  input  logic [WID-1:0]  idat,
  input  logic            ordy,
  output logic            ovld,
  output logic [RIDW-1:0] orid,
  output logic [1:0]      osta,
  output logic            ohit,
  output logic            ofull,
  output logic            oovf,
  output logic [15:0]     ohcnt
);

  localparam int AW = (DEP > 1) ? $clog2(DEP) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEP);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_NONE   = 2'b00,
    ST_SINGLE = 2'b01,
    ST_MULTI  = 2'b10,
    ST_ERR    = 2'b11
  } status_e;

  logic [WID-1:0] mem [DEP];
  logic [AW-1:0]  wptr, rptr, rptr_nx;
  logic [CW-1:0]  cnt;
  logic [WID-1:0] nxt_word;
  status_e        in_sta;
  logic           empty, filt, pop, push;

  assign in_sta   = status_e'(idat[WID-1:WID-2]);
  assign empty    = (cnt == '0);
  assign ofull    = (cnt == CNT_FULL);
  assign ovld     = !empty;
  assign ohit     = ovld && (osta == ST_SINGLE);
  assign filt     = (DROPNM == 1) && (in_sta == ST_NONE);
  assign pop      = ovld && ordy;
  assign push     = ivld && !filt && (!ofull || pop);
  assign rptr_nx  = rptr + 1'b1;
  assign nxt_word = mem[rptr_nx];

  // NOTE: the storage array carries no reset; pointers and occupancy define
  // which entries are live, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= idat;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      oovf  <= 1'b0;
      ohcnt <= '0;
      orid  <= '0;
      osta  <= ST_NONE;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr_nx;

      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase

      if (ivld && !filt && ofull && !pop) oovf <= 1'b1;

      if (pop && (osta == ST_SINGLE) && (ohcnt != 16'hFFFF)) ohcnt <= ohcnt + 16'd1;

      // Head register mirrors mem[rptr]: refill from the next entry on pop,
      // or take the incoming word when it becomes the only entry.
      if (pop && (cnt > CNT_ONE)) begin
        orid <= nxt_word[RIDW-1:0];
        osta <= nxt_word[WID-1:WID-2];
      end else if (push && (empty || (pop && cnt == CNT_ONE))) begin
        orid <= idat[RIDW-1:0];
        osta <= idat[WID-1:WID-2];
      end
    end
  end

endmodule

// File: tb/tb_tcam_rslt_rdr.sv
// Scoreboard bench for tcam_rslt_rdr: one pass-through instance and one
// no-match-dropping instance, directed vectors with hand-computed expectations.
module tb_tcam_rslt_rdr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        ivld = 1'b0, ordy = 1'b0;
  logic [9:0]  idat = '0;
  logic        ovld, ohit, ofull, oovf;
  logic [7:0]  orid;
  logic [1:0]  osta;
  logic [15:0] ohcnt;

  logic        d_ivld = 1'b0, d_ordy = 1'b0;
  logic [9:0]  d_idat = '0;
  logic        d_ovld, d_ohit, d_ofull, d_oovf;
  logic [7:0]  d_orid;
  logic [1:0]  d_osta;
  logic [15:0] d_ohcnt;

  logic [9:0]  expq[$];
  logic [9:0]  dexpq[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  tcam_rslt_rdr #(.WID(10), .RIDW(8), .DEP(4), .DROPNM(0)) u_dut (
    .clk(clk), .rst(rst), .ivld(ivld), .idat(idat), .ordy(ordy),
    .ovld(ovld), .orid(orid), .osta(osta), .ohit(ohit),
    .ofull(ofull), .oovf(oovf), .ohcnt(ohcnt)
  );

  tcam_rslt_rdr #(.WID(10), .RIDW(8), .DEP(4), .DROPNM(1)) u_drop (
    .clk(clk), .rst(rst), .ivld(d_ivld), .idat(d_idat), .ordy(d_ordy),
    .ovld(d_ovld), .orid(d_orid), .osta(d_osta), .ohit(d_ohit),
    .ofull(d_ofull), .oovf(d_oovf), .ohcnt(d_ohcnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitors: every accepted head word is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst && ovld && ordy) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL main_unexpected: actual=%0h required=none", {osta, orid});
      end else begin
        logic [9:0] e;
        e = expq.pop_front();
        check("main_word", {22'd0, osta, orid}, {22'd0, e});
        check("main_hit", {31'd0, ohit}, {31'd0, e[9:8] == 2'b01});
      end
    end
  end

  always @(negedge clk) begin
    if (rst && d_ovld && d_ordy) begin
      if (dexpq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL drop_unexpected: actual=%0h required=none", {d_osta, d_orid});
      end else begin
        logic [9:0] e;
        e = dexpq.pop_front();
        check("drop_word", {22'd0, d_osta, d_orid}, {22'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; ivld = 1'b0; ordy = 1'b0; d_ivld = 1'b0; d_ordy = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic drain(input bit drop, input string name);
    bit done;
    done = 1'b0;
    if (drop) d_ordy = 1'b1; else ordy = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (drop) done = !d_ovld && (dexpq.size() == 0);
      else      done = !ovld && (expq.size() == 0);
    end
    check(name, {31'd0, done}, 32'd1);
    if (drop) d_ordy = 1'b0; else ordy = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_ovld",  {31'd0, ovld},  32'd0);
    check("rst_ofull", {31'd0, ofull}, 32'd0);
    check("rst_ohit",  {31'd0, ohit},  32'd0);
    check("rst_orid",  {24'd0, orid},  32'd0);
    check("rst_osta",  {30'd0, osta},  32'd0);
    check("rst_oovf",  {31'd0, oovf},  32'd0);
    check("rst_ohcnt", {16'd0, ohcnt}, 32'd0);
    rst = 1'b1;

    // Single-match word, one-cycle fall-through latency
    ordy = 1'b1; ivld = 1'b1; idat = 10'h105; expq.push_back(10'h105);
    tick();
    ivld = 1'b0;
    check("t1_ovld", {31'd0, ovld}, 32'd1);
    check("t1_orid", {24'd0, orid}, 32'h05);
    check("t1_osta", {30'd0, osta}, 32'd1);
    check("t1_ohit", {31'd0, ohit}, 32'd1);
    tick();
    check("t1_ohcnt", {16'd0, ohcnt}, 32'd1);
    check("t1_empty", {31'd0, ovld},  32'd0);
    ordy = 1'b0;

    // Fill past capacity with consumer stalled
    for (int i = 1; i <= 5; i++) begin
      ivld = 1'b1; idat = 10'h100 | 10'(i);
      if (i <= 4) expq.push_back(10'h100 | 10'(i));
      tick();
      if (i == 3) check("t2_notfull", {31'd0, ofull}, 32'd0);
      if (i == 4) begin
        check("t2_full4", {31'd0, ofull}, 32'd1);
        check("t2_noovf4", {31'd0, oovf}, 32'd0);
      end
      if (i == 5) begin
        check("t2_full5", {31'd0, ofull}, 32'd1);
        check("t2_ovf5", {31'd0, oovf}, 32'd1);
      end
    end
    ivld = 1'b0;
    drain(1'b0, "t2_drain");
    check("t2_ohcnt", {16'd0, ohcnt}, 32'd5);
    check("t2_ovf_sticky", {31'd0, oovf}, 32'd1);

    // Full buffer with simultaneous push and pop
    do_reset();
    check("t3_ovf_cleared", {31'd0, oovf}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      ivld = 1'b1; idat = 10'h210 + 10'(i); expq.push_back(10'h210 + 10'(i));
      tick();
    end
    ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ivld = 1'b1; idat = 10'h220 + 10'(i); expq.push_back(10'h220 + 10'(i));
      tick();
      check("t3_full", {31'd0, ofull}, 32'd1);
    end
    ivld = 1'b0;
    drain(1'b0, "t3_drain");
    check("t3_noovf", {31'd0, oovf}, 32'd0);

    // Reset with buffered words and concurrent push; push on first edge after
    ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ivld = 1'b1; idat = 10'h130 + 10'(i);
      tick();
    end
    rst = 1'b0; ivld = 1'b1; idat = 10'h1EE;
    tick();
    check("t4_ovld",  {31'd0, ovld},  32'd0);
    check("t4_ohcnt", {16'd0, ohcnt}, 32'd0);
    check("t4_oovf",  {31'd0, oovf},  32'd0);
    check("t4_orid",  {24'd0, orid},  32'd0);
    rst = 1'b1; ivld = 1'b1; idat = 10'h2AA; ordy = 1'b1; expq.push_back(10'h2AA);
    tick();
    ivld = 1'b0;
    check("t4_first_push", {31'd0, ovld}, 32'd1);
    drain(1'b0, "t4_drain");

    // No-match filtering
    d_ordy = 1'b1;
    d_ivld = 1'b1; d_idat = 10'h011; tick();
    d_idat = 10'h222; dexpq.push_back(10'h222); tick();
    d_idat = 10'h033; tick();
    d_idat = 10'h344; dexpq.push_back(10'h344); tick();
    d_ivld = 1'b0;
    drain(1'b1, "t5_drain");
    check("t5_noovf", {31'd0, d_oovf}, 32'd0);
    d_ordy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d_ivld = 1'b1; d_idat = 10'h250 + 10'(i); dexpq.push_back(10'h250 + 10'(i));
      tick();
    end
    d_idat = 10'h000; tick();
    check("t5_filt_full", {31'd0, d_ofull}, 32'd1);
    check("t5_filt_noovf", {31'd0, d_oovf}, 32'd0);
    d_idat = 10'h160; tick();
    d_ivld = 1'b0;
    check("t5_ovf", {31'd0, d_oovf}, 32'd1);
    drain(1'b1, "t5_drain2");

    // Hit counter saturation
    do_reset();
    ordy = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      ivld = 1'b1; idat = 10'h100 | 10'(i[7:0]); expq.push_back(10'h100 | 10'(i[7:0]));
      tick();
    end
    ivld = 1'b0;
    drain(1'b0, "t6_drain");
    check("t6_fffe", {16'd0, ohcnt}, 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      ivld = 1'b1; idat = 10'h1C0 + 10'(i); expq.push_back(10'h1C0 + 10'(i));
      tick();
    end
    ivld = 1'b0;
    drain(1'b0, "t6_drain2");
    check("t6_ffff", {16'd0, ohcnt}, 32'hFFFF);
    tick();
    check("t6_hold", {16'd0, ohcnt}, 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
